// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: machine word and request-unit state encoding
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - saturating stall counter with a sticky timeout flag
module stall_watchdog #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(MAX_WAIT);

  logic [15:0] count_q, count_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT)) begin
      count_d = count_q + 16'd1;
    end
    // Flag rises on the edge the count lands on the limit, so it is visible the following cycle.
    timeout_d = timeout_q | (count_d == LIMIT);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - sequences instruction fetch, one data access and halt between control unit and memory
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t pc,
  input  logic  cu_dREN,
  input  logic  cu_dWEN,
  input  logic  cu_halt,
  input  word_t alu_out,
  input  word_t store_data,
  input  logic  ihit,
  input  logic  dhit,
  output logic  imemREN,
  output word_t imemaddr,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  pc_en,
  output logic  halt,
  output logic  timeout
);

  reqstate_t state_q, state_d;
  word_t     addr_q, addr_d;
  word_t     store_q, store_d;
  logic      ren_q, ren_d;
  logic      wen_q, wen_d;
  logic      count_en, hit_taken, wd_clear;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    pc_en     = 1'b0;
    count_en  = 1'b0;
    hit_taken = 1'b0;

    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          hit_taken = 1'b1;
          if (cu_halt) begin
            state_d = HALTED;
          end else if (cu_dREN || cu_dWEN) begin
            state_d = DATA;
            addr_d  = alu_out;
            store_d = store_data;
            ren_d   = cu_dREN;
            wen_d   = cu_dWEN;
          end else begin
            pc_en = 1'b1;
          end
        end else begin
          count_en = 1'b1;
        end
      end
      DATA: begin
        dmemWEN = wen_q;
        dmemREN = ren_q & ~wen_q;
        if (dhit) begin
          hit_taken = 1'b1;
          pc_en     = 1'b1;
          state_d   = FETCH;
          ren_d     = 1'b0;
          wen_d     = 1'b0;
        end else begin
          count_en = 1'b1;
        end
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase

    // While reset is held the memory side already sees an idle fetch, never a stale data request.
    if (!nRST) begin
      imemREN = 1'b1;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      pc_en   = 1'b0;
    end
  end

  assign wd_clear  = hit_taken | (state_d != state_q);
  assign imemaddr  = pc;
  assign dmemaddr  = nRST ? addr_q : '0;
  assign dmemstore = nRST ? store_q : '0;
  assign halt      = (state_q == HALTED);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

  stall_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_stall_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .count_en(count_en),
    .clear   (wd_clear),
    .timeout (timeout)
  );

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed and random stimulus against a transaction-level model of request_unit
module tb_request_unit;

  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc, alu_out, store_data;
  logic        cu_dREN, cu_dWEN, cu_halt, ihit, dhit;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt, timeout;
  logic [31:0] imemaddr, dmemaddr, dmemstore;

  always #5 CLK = ~CLK;

  request_unit #(.MAX_WAIT(MW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .pc        (pc),
    .cu_dREN   (cu_dREN),
    .cu_dWEN   (cu_dWEN),
    .cu_halt   (cu_halt),
    .alu_out   (alu_out),
    .store_data(store_data),
    .ihit      (ihit),
    .dhit      (dhit),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .pc_en     (pc_en),
    .halt      (halt),
    .timeout   (timeout)
  );

  int checks = 0;
  int failures = 0;

  // Model: is a data access pending, what was captured, is the core halted, how long it has waited.
  bit          m_halted, m_busy, m_rd, m_wr, m_to;
  logic [31:0] m_addr, m_data;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic ih, input logic dh, input logic r,
                      input logic w, input logic hl, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] s);
    logic        e_i, e_r, e_w, e_p, chk_d;
    logic [31:0] e_addr, e_st;
    bit          stalled;
    @(negedge CLK);
    nRST = rn; ihit = ih; dhit = dh; cu_dREN = r; cu_dWEN = w; cu_halt = hl;
    pc = p; alu_out = a; store_data = s;
    #1;
    e_addr = '0; e_st = '0; chk_d = 1'b0;
    if (!rn) begin
      e_i = 1'b1; e_r = 1'b0; e_w = 1'b0; e_p = 1'b0; chk_d = 1'b1;
    end else if (m_halted) begin
      e_i = 1'b0; e_r = 1'b0; e_w = 1'b0; e_p = 1'b0;
    end else if (m_busy) begin
      e_i = 1'b0; e_w = m_wr; e_r = m_rd && !m_wr; e_p = dh;
      chk_d = 1'b1; e_addr = m_addr; e_st = m_data;
    end else begin
      e_i = 1'b1; e_r = 1'b0; e_w = 1'b0; e_p = ih && !hl && !(r || w);
    end
    check("imemREN", {31'd0, imemREN}, {31'd0, e_i});
    if (e_i) check("imemaddr", imemaddr, p);
    check("dmemREN", {31'd0, dmemREN}, {31'd0, e_r});
    check("dmemWEN", {31'd0, dmemWEN}, {31'd0, e_w});
    if (chk_d) begin
      check("dmemaddr", dmemaddr, e_addr);
      check("dmemstore", dmemstore, e_st);
    end
    check("pc_en", {31'd0, pc_en}, {31'd0, e_p});
    check("halt", {31'd0, halt}, {31'd0, m_halted});
    check("timeout", {31'd0, timeout}, {31'd0, m_to});

    @(posedge CLK);
    if (!rn) begin
      m_halted = 0; m_busy = 0; m_rd = 0; m_wr = 0; m_to = 0;
      m_addr = '0; m_data = '0; m_cnt = 0;
    end else if (!m_halted) begin
      stalled = m_busy ? !dh : !ih;
      if (stalled) begin
        if (m_cnt < MW) m_cnt++;
        if (m_cnt == MW) m_to = 1;
      end else begin
        m_cnt = 0;
      end
      if (m_busy) begin
        if (dh) begin
          m_busy = 0; m_rd = 0; m_wr = 0;
        end
      end else if (ih) begin
        if (hl) m_halted = 1;
        else if (r || w) begin
          m_busy = 1; m_addr = a; m_data = s; m_rd = r; m_wr = w;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    nRST = 0; ihit = 0; dhit = 0; cu_dREN = 0; cu_dWEN = 0; cu_halt = 0;
    pc = '0; alu_out = '0; store_data = '0;
    m_halted = 0; m_busy = 0; m_rd = 0; m_wr = 0; m_to = 0;
    m_addr = '0; m_data = '0; m_cnt = 0;

    do_reset();
    do_reset();
    step(1, 1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0);

    // Load from 0x100 with a three-cycle data stall.
    step(1, 1, 0, 1, 0, 0, 32'h44, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 32'h48, 32'h0, 32'h0);
    step(1, 0, 1, 0, 0, 0, 32'h48, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h48, 32'h0, 32'h0);

    // Read and write both set: write wins.
    do_reset();
    step(1, 1, 0, 1, 1, 0, 32'h80, 32'h200, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 32'h84, 32'h0, 32'h0);
    step(1, 0, 1, 0, 0, 0, 32'h84, 32'h0, 32'h0);

    // Watchdog with ihit held low, then a late hit.
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 32'hC0, 32'h0, 32'h0);
    step(1, 1, 0, 0, 0, 0, 32'hC0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'hC4, 32'h0, 32'h0);

    // Reset in the second cycle of a data access.
    do_reset();
    step(1, 1, 0, 1, 0, 0, 32'h10, 32'h300, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h14, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h14, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h14, 32'h0, 32'h0);
    step(1, 1, 0, 0, 0, 0, 32'h14, 32'h0, 32'h0);

    // Halt together with a store request, then 100 cycles of noise.
    do_reset();
    step(1, 1, 0, 0, 1, 1, 32'h20, 32'h400, 32'h1234);
    for (int i = 0; i < 100; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, $urandom);

    // Random traffic with occasional halts and resets.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 39) == 0), $urandom, $urandom, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 255, stall cycles tolerated before timeout (legal 1..65535).
REQ-002 SHALL have port: CLK  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: nRST  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: pc  in  32 (word_t)  current fetch address.
REQ-005 SHALL have port: cu_dREN, cu_dWEN, cu_halt  in  1 each  decoded control from control unit, valid only in the cycle ihit=1.
REQ-006 SHALL have port: alu_out  in  32  data address; store_data  in  32  rt value for stores; both valid with ihit.
REQ-007 SHALL have port: ihit, dhit  in  1 each  memory completion strobes.
REQ-008 SHALL have port: imemREN  out  1; imemaddr  out  32  instruction request.
REQ-009 SHALL have port: dmemREN, dmemWEN  out  1 each; dmemaddr, dmemstore  out  32 each  data request.
REQ-010 SHALL have port: pc_en  out  1  one-cycle PC advance strobe.
REQ-011 SHALL have port: halt  out  1 sticky halt; timeout  out  1 sticky stall watchdog flag.

Function
REQ-012 SHALL implement states FETCH, DATA, HALTED; one state register.
REQ-013 FETCH: imemREN=1, imemaddr=pc (combinational), dmemREN=dmemWEN=0.
REQ-014 FETCH, ihit=1, cu_halt=1: next HALTED, pc_en=0; cu_halt overrides cu_dREN/cu_dWEN.
REQ-015 FETCH, ihit=1, cu_dREN|cu_dWEN, cu_halt=0: next DATA, pc_en=0, capture alu_out, store_data, cu_dREN, cu_dWEN into registers.
REQ-016 FETCH, ihit=1, no data op, no halt: stay FETCH, pc_en=1 same cycle.
REQ-017 FETCH, ihit=0: stay FETCH, pc_en=0.
REQ-018 DATA: imemREN=0; dmemaddr/dmemstore from captured registers; dmemREN/dmemWEN from captured flags.
REQ-019 Captured cu_dREN and cu_dWEN both 1: dmemWEN=1, dmemREN=0 (write wins).
REQ-020 DATA, dhit=1: pc_en=1 same cycle, next FETCH, captured flags cleared.
REQ-021 DATA, dhit=0: hold all data outputs stable, pc_en=0.
REQ-022 HALTED: all REN/WEN and pc_en 0, halt=1; exits only on reset.
REQ-023 ihit during DATA and dhit during FETCH SHALL be ignored.
REQ-024 pc_en SHALL never be high two consecutive cycles without an intervening hit.
REQ-025 Watchdog: 16-bit counter increments each cycle in FETCH with ihit=0 or DATA with dhit=0; cleared on any accepted hit and on state change.
REQ-026 Counter saturates at MAX_WAIT; when count reaches MAX_WAIT, timeout SHALL assert next cycle and stay high until reset; requests continue unchanged.
REQ-027 Watchdog SHALL not count in HALTED.

Reset
REQ-028 nRST=0 at a rising edge: state FETCH, captured address/data/flags 0, counter 0, halt=0, timeout=0.
REQ-029 During and after reset cycle, outputs: imemREN=1 (FETCH), dmemREN=dmemWEN=0, pc_en=0, dmemaddr=dmemstore=0.
REQ-030 Reset asserted mid-DATA SHALL drop the pending data request on the following cycle without pc_en.

Structure
REQ-031 State enum reqstate_t (FETCH, DATA, HALTED) SHALL reside in cpu_types_pkg; word_t reused from it.
REQ-032 Watchdog SHALL be sub-module stall_watchdog (inputs CLK, nRST, count_en, clear; parameter MAX_WAIT; output timeout).
REQ-033 No other sub-modules; request_unit SHALL be the single instantiation point between control unit and memory.

Verification
REQ-034 Reset then pc=0x40, ihit=1, no data op -> imemaddr=0x40, pc_en=1 that cycle, state FETCH.
REQ-035 ihit with cu_dREN=1, alu_out=0x100; dhit after 3 cycles -> dmemREN=1, dmemaddr=0x100 for 4 cycles, pc_en=1 only in dhit cycle, then imemREN=1.
REQ-036 ihit with cu_dWEN=cu_dREN=1, store_data=0xDEADBEEF -> dmemWEN=1, dmemREN=0, dmemstore=0xDEADBEEF held until dhit.
REQ-037 ihit with cu_halt=1, cu_dWEN=1 -> halt=1 next cycle, no dmemWEN ever, pc_en=0, persists for 100 cycles.
REQ-038 MAX_WAIT=4, ihit held 0 -> timeout=1 on 5th cycle, imemREN stays 1; later ihit does not clear timeout.
REQ-039 nRST=0 in second DATA cycle -> next cycle dmemREN=0, imemREN=1, pc_en=0, counter 0.
